// File: rtl/alu_flag_stage_if.sv
// Sequencer-facing bundle of the ALU flag stage: request operands and the
// registered result/flag/strobe outputs that feed the status register.
interface alu_flag_stage_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic [WIDTH-1:0] y;
  logic             cFlag;
  logic             zFlag;
  logic             notLoadStatus;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, cIn,
    input  y, cFlag, zFlag, notLoadStatus, busy, done
  );

  modport slave (
    input  start, op, a, b, cIn,
    output y, cFlag, zFlag, notLoadStatus, busy, done
  );
endinterface

// File: rtl/alu_flag_stage.sv
// ALU stage ahead of the status register: single-cycle add/sub/logic ops,
// one-bit-per-clock shifts, and a one-cycle active-low status load strobe.
module alu_flag_stage #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  alu_flag_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  state_t           state_r;
  logic [WIDTH-1:0] y_r;
  logic             c_r;
  logic             z_r;
  logic             busy_r;
  logic             done_r;
  logic             nload_r;
  logic             shl_r;
  logic [SHW-1:0]   cnt_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] b_opnd_s;
  logic             carry_in_s;
  logic [WIDTH-1:0] shifted_s;
  logic             shift_out_s;
  logic [SHW-1:0]   amt_s;

  // Operand conditioning for the (WIDTH+1)-bit adder used by all arithmetic ops.
  always_comb begin
    b_opnd_s   = bus.b;
    carry_in_s = 1'b0;
    case (bus.op)
      OP_ADD: begin
        b_opnd_s   = bus.b;
        carry_in_s = 1'b0;
      end
      OP_ADC: begin
        b_opnd_s   = bus.b;
        carry_in_s = bus.cIn;
      end
      OP_SUB: begin
        b_opnd_s   = ~bus.b;
        carry_in_s = 1'b1;
      end
      OP_SBC: begin
        b_opnd_s   = ~bus.b;
        carry_in_s = bus.cIn;
      end
      default: begin
        b_opnd_s   = bus.b;
        carry_in_s = 1'b0;
      end
    endcase
    sum_s = {1'b0, bus.a} + {1'b0, b_opnd_s} + {{WIDTH{1'b0}}, carry_in_s};
  end

  // One-bit shift of the work register (held in y_r) and the bit that falls out.
  always_comb begin
    if (shl_r) begin
      shifted_s   = {y_r[WIDTH-2:0], 1'b0};
      shift_out_s = y_r[WIDTH-1];
    end else begin
      shifted_s   = {1'b0, y_r[WIDTH-1:1]};
      shift_out_s = y_r[0];
    end
    amt_s = bus.b[SHW-1:0];
  end

  // Control FSM with all handshake, result and flag outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      y_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      z_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      nload_r <= 1'b1;
      shl_r   <= 1'b0;
      cnt_r   <= {SHW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          nload_r <= 1'b1;
          if (bus.start) begin
            busy_r <= 1'b1;
            case (bus.op)
              OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                y_r     <= sum_s[WIDTH-1:0];
                c_r     <= sum_s[WIDTH];
                z_r     <= (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
                state_r <= DONE;
                done_r  <= 1'b1;
                nload_r <= 1'b0;
              end
              OP_AND: begin
                y_r     <= bus.a & bus.b;
                c_r     <= 1'b0;
                z_r     <= ((bus.a & bus.b) == {WIDTH{1'b0}});
                state_r <= DONE;
                done_r  <= 1'b1;
                nload_r <= 1'b0;
              end
              OP_OR: begin
                y_r     <= bus.a | bus.b;
                c_r     <= 1'b0;
                z_r     <= ((bus.a | bus.b) == {WIDTH{1'b0}});
                state_r <= DONE;
                done_r  <= 1'b1;
                nload_r <= 1'b0;
              end
              OP_SHL, OP_SHR: begin
                y_r   <= bus.a;
                shl_r <= (bus.op == OP_SHL);
                cnt_r <= amt_s;
                if (amt_s == {SHW{1'b0}}) begin
                  c_r     <= 1'b0;
                  z_r     <= (bus.a == {WIDTH{1'b0}});
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  nload_r <= 1'b0;
                end else begin
                  state_r <= SHIFT;
                end
              end
              default: begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          y_r   <= shifted_s;
          c_r   <= shift_out_s;
          cnt_r <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            z_r     <= (shifted_s == {WIDTH{1'b0}});
            state_r <= DONE;
            done_r  <= 1'b1;
            nload_r <= 1'b0;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          nload_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          nload_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.y             = y_r;
  assign bus.cFlag         = c_r;
  assign bus.zFlag         = z_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.notLoadStatus = nload_r;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed-vector bench for alu_flag_stage with hand-computed results,
// latencies and strobe counts.
module tb_alu_flag_stage;
  logic clock;
  logic reset;
  int   test_cnt;
  int   fail_cnt;
  int   strobe_cnt;

  alu_flag_stage_if #(.WIDTH(16)) bus ();

  alu_flag_stage #(.WIDTH(16), .SHW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mid-cycle tally of low strobe cycles.
  always @(negedge clock) begin
    if (!bus.notLoadStatus) strobe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci, input int exp_lat,
                        input logic [15:0] ey, input logic ec, input logic ez);
    int lat;
    int s0;
    @(negedge clock);
    bus.op = o; bus.a = av; bus.b = bv; bus.cIn = ci; bus.start = 1'b1;
    s0 = strobe_cnt;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_y"}, 32'(bus.y), 32'(ey));
    check({tag, "_c"}, 32'(bus.cFlag), 32'(ec));
    check({tag, "_z"}, 32'(bus.zFlag), 32'(ez));
    check({tag, "_nload"}, 32'(bus.notLoadStatus), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    @(posedge clock); #1;
    check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_nload_clr"}, 32'(bus.notLoadStatus), 32'd1);
    check({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    check({tag, "_y_hold"}, 32'(bus.y), 32'(ey));
    check({tag, "_strobes"}, 32'(strobe_cnt - s0), 32'd1);
  endtask

  initial begin
    int s0;
    test_cnt = 0; fail_cnt = 0; strobe_cnt = 0;
    bus.start = 1'b0; bus.op = 3'd0; bus.a = 16'h0000; bus.b = 16'h0000; bus.cIn = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_flags", 32'({bus.cFlag, bus.zFlag}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_nload", 32'(bus.notLoadStatus), 32'd1);
    @(negedge clock); reset = 1'b0;

    run_op("add", 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
    run_op("adc", 3'b001, 16'h0001, 16'h0001, 1'b1, 1, 16'h0003, 1'b0, 1'b0);
    run_op("sub_eq", 3'b010, 16'h0005, 16'h0005, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
    run_op("sub_neg", 3'b010, 16'h0003, 16'h0005, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sbc", 3'b011, 16'h0005, 16'h0005, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0);
    run_op("and", 3'b100, 16'hF0F0, 16'h0F0F, 1'b1, 1, 16'h0000, 1'b0, 1'b1);
    run_op("or", 3'b101, 16'h0000, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, 1'b1);
    run_op("or_nz", 3'b101, 16'h1200, 16'h0034, 1'b0, 1, 16'h1234, 1'b0, 1'b0);
    run_op("shl1", 3'b110, 16'h8001, 16'h0001, 1'b0, 2, 16'h0002, 1'b1, 1'b0);
    run_op("shr15", 3'b111, 16'h8001, 16'h000F, 1'b0, 16, 16'h0001, 1'b0, 1'b0);
    run_op("shr0", 3'b111, 16'h0001, 16'h0010, 1'b1, 1, 16'h0001, 1'b0, 1'b0);
    run_op("shr_z", 3'b111, 16'h0001, 16'h0001, 1'b0, 2, 16'h0000, 1'b1, 1'b1);

    // Reset in the middle of an 8-step left shift.
    @(negedge clock);
    bus.op = 3'b110; bus.a = 16'h0001; bus.b = 16'h0008; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    s0 = strobe_cnt;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_y", 32'(bus.y), 32'd0);
    check("mid_rst_flags", 32'({bus.cFlag, bus.zFlag}), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_nload", 32'(bus.notLoadStatus), 32'd1);
    @(negedge clock); reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("mid_rst_no_done", 32'(bus.done), 32'd0);
    check("mid_rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    run_op("add_after_rst", 3'b000, 16'h1234, 16'h0101, 1'b0, 1, 16'h1335, 1'b0, 1'b0);

    // start held high through SHIFT and DONE: one acceptance per IDLE visit.
    @(negedge clock);
    bus.op = 3'b110; bus.a = 16'h0001; bus.b = 16'h0002; bus.start = 1'b1;
    s0 = strobe_cnt;
    @(posedge clock); #1;
    check("hold_c1_done", 32'(bus.done), 32'd0);
    @(posedge clock); #1;
    check("hold_c2_done", 32'(bus.done), 32'd0);
    bus.a = 16'h0003;
    @(posedge clock); #1;
    check("hold_c3_done", 32'(bus.done), 32'd1);
    check("hold_c3_y", 32'(bus.y), 32'h0004);
    @(posedge clock); #1;
    check("hold_c4_busy", 32'(bus.busy), 32'd0);
    check("hold_c4_done", 32'(bus.done), 32'd0);
    @(posedge clock); #1;
    check("hold_c5_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    @(posedge clock); #1;
    check("hold_c6_done", 32'(bus.done), 32'd0);
    @(posedge clock); #1;
    check("hold_c7_done", 32'(bus.done), 32'd1);
    check("hold_c7_y", 32'(bus.y), 32'h000C);
    @(posedge clock); #1;
    check("hold_strobes", 32'(strobe_cnt - s0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule
